// File: rtl/nonce_tx_arbiter.sv
// nonce_tx_arbiter: holds one golden nonce per slave and grants them round-robin
// onto a single serial transmitter using a send/busy handshake.
module nonce_tx_arbiter #(
    parameter int SLAVES       = 2,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SLAVES*32-1:0]   slave_nonces,
    input  logic [SLAVES-1:0]      new_nonces,
    input  logic                   serial_busy,
    output logic                   serial_send,
    output logic [31:0]            golden_nonce,
    output logic [SLAVES-1:0]      pending,
    output logic [SLAVES-1:0]      dropped,
    output logic                   tx_timeout,
    output logic [15:0]            sent_count
);
    localparam int GW = SLAVES > 1 ? $clog2(SLAVES) : 1;
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

    state_t            state_q, state_d;
    logic [31:0]       hold_q [SLAVES];
    logic [31:0]       hold_d [SLAVES];
    logic [SLAVES-1:0] pend_q, pend_d, drop_q, drop_d;
    logic [GW-1:0]     last_q, last_d, gnt;
    logic              gnt_v, grant;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              send_q, send_d, to_q, to_d;
    logic [31:0]       gold_q, gold_d;
    logic [15:0]       sent_q, sent_d;

    // Walk from farthest to nearest so the slot right after last_q wins.
    always_comb begin
        gnt   = last_q;
        gnt_v = 1'b0;
        for (int k = SLAVES; k >= 1; k--) begin
            if (pend_q[(int'(last_q) + k) % SLAVES]) begin
                gnt   = GW'((int'(last_q) + k) % SLAVES);
                gnt_v = 1'b1;
            end
        end
    end

    assign grant = (state_q == IDLE) && !serial_busy && gnt_v;

    // A strobe on the granted slave refills its slot without counting as a drop.
    always_comb begin
        hold_d = hold_q;
        pend_d = pend_q;
        drop_d = drop_q;
        for (int i = 0; i < SLAVES; i++) begin
            hold_d[i] = new_nonces[i] ? slave_nonces[i*32 +: 32] : hold_q[i];
            pend_d[i] = new_nonces[i] | (pend_q[i] & ~(grant && gnt == GW'(i)));
            drop_d[i] = drop_q[i] | (new_nonces[i] & pend_q[i] & ~(grant && gnt == GW'(i)));
        end
    end

    always_comb begin
        state_d = state_q;
        send_d  = 1'b0;
        cnt_d   = cnt_q;
        to_d    = to_q;
        gold_d  = gold_q;
        sent_d  = sent_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    gold_d  = hold_q[gnt];
                    last_d  = gnt;
                    send_d  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (serial_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                        to_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!serial_busy) begin
                    sent_d  = sent_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '{default: '0};
            pend_q  <= '0;
            drop_q  <= '0;
            last_q  <= GW'(SLAVES - 1);
            cnt_q   <= '0;
            send_q  <= 1'b0;
            to_q    <= 1'b0;
            gold_q  <= '0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            send_q  <= send_d;
            to_q    <= to_d;
            gold_q  <= gold_d;
            sent_q  <= sent_d;
        end
    end

    assign serial_send  = send_q;
    assign golden_nonce = gold_q;
    assign pending      = pend_q;
    assign dropped      = drop_q;
    assign tx_timeout   = to_q;
    assign sent_count   = sent_q;
endmodule

// File: tb/tb_nonce_tx_arbiter.sv
// tb_nonce_tx_arbiter: directed table, hand-written corner cases and a randomized
// run against a slot/queue level model of the arbiter plus a behavioural transmitter.
module tb_nonce_tx_arbiter;
    localparam int SL = 2;
    localparam int TO = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic [SL*32-1:0] slave_nonces;
    logic [SL-1:0]    new_nonces;
    logic             serial_busy;
    logic             serial_send;
    logic [31:0]      golden_nonce;
    logic [SL-1:0]    pending;
    logic [SL-1:0]    dropped;
    logic             tx_timeout;
    logic [15:0]      sent_count;

    int checks = 0;
    int errors = 0;

    nonce_tx_arbiter #(.SLAVES(SL), .BUSY_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .slave_nonces(slave_nonces), .new_nonces(new_nonces),
        .serial_busy(serial_busy), .serial_send(serial_send), .golden_nonce(golden_nonce),
        .pending(pending), .dropped(dropped), .tx_timeout(tx_timeout), .sent_count(sent_count)
    );

    always #5 clk = ~clk;

    logic [31:0] m_hold [SL];
    logic [SL-1:0] m_pend, m_drop;
    int          m_last;
    logic        m_idle, m_to, m_send;
    logic [31:0] m_gold;
    logic [15:0] m_sent;

    int   tx_len = 8;
    int   busy_left = 0;
    int   tcnt = 0;
    int   ignore_n = 0;
    logic inc_next = 1'b0;
    int   step_no = 0;
    logic [31:0] dut_sends[$];

    typedef struct packed {
        logic [2:0][1:0]  s;
        logic [2:0][31:0] v0;
        logic [2:0][31:0] v1;
        int               gap;
        int               nexp;
        logic [3:0][31:0] exp;
        logic [1:0]       drop;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (step %0d)", name, act, exp, step_no);
        end
    endtask

    task automatic strobe(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
        new_nonces   = s;
        slave_nonces = {b, a};
    endtask

    task automatic step();
        int g;
        @(posedge clk);
        #1;
        step_no++;
        if (reset) begin
            for (int i = 0; i < SL; i++) m_hold[i] = '0;
            m_pend = '0; m_drop = '0; m_last = SL - 1; m_idle = 1'b1; m_to = 1'b0;
            m_gold = '0; m_sent = '0; m_send = 1'b0;
            tcnt = 0; inc_next = 1'b0; busy_left = 0; ignore_n = 0; serial_busy = 1'b0;
        end else begin
            m_send = m_idle && (m_pend != '0) && !serial_busy;
            if (m_send) begin
                g = -1;
                for (int k = 1; k <= SL; k++)
                    if (g < 0 && m_pend[(m_last + k) % SL]) g = (m_last + k) % SL;
                m_gold = m_hold[g]; m_pend[g] = 1'b0; m_last = g; m_idle = 1'b0;
            end
            for (int i = 0; i < SL; i++) begin
                if (new_nonces[i]) begin
                    if (m_pend[i]) m_drop[i] = 1'b1;
                    m_hold[i] = slave_nonces[i*32 +: 32];
                    m_pend[i] = 1'b1;
                end
            end
            if (inc_next) begin m_sent++; m_idle = 1'b1; inc_next = 1'b0; end
            if (tcnt > 0) begin
                tcnt--;
                if (tcnt == 0) begin m_to = 1'b1; m_idle = 1'b1; end
            end
        end
        if (serial_send) dut_sends.push_back(golden_nonce);
        chk("serial_send", 32'(serial_send), 32'(m_send));
        chk("golden_nonce", golden_nonce, m_gold);
        chk("pending", 32'(pending), 32'(m_pend));
        chk("dropped", 32'(dropped), 32'(m_drop));
        chk("tx_timeout", 32'(tx_timeout), 32'(m_to));
        chk("sent_count", 32'(sent_count), 32'(m_sent));
        if (!reset) begin
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin serial_busy = 1'b0; inc_next = 1'b1; end
            end else if (serial_send) begin
                if (ignore_n > 0) begin ignore_n--; tcnt = TO + 1; end
                else begin serial_busy = 1'b1; busy_left = tx_len; end
            end
        end
        new_nonces = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        dut_sends.delete();
    endtask

    function automatic vec_t mk(input logic [1:0] s0, input logic [31:0] a0, input logic [31:0] b0,
                                input logic [1:0] s1, input logic [31:0] a1, input logic [31:0] b1,
                                input logic [1:0] s2, input logic [31:0] a2, input logic [31:0] b2,
                                input int gap, input int nexp,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3, input logic [1:0] drop);
        vec_t v;
        v.s = {s2, s1, s0}; v.v0 = {a2, a1, a0}; v.v1 = {b2, b1, b0};
        v.gap = gap; v.nexp = nexp; v.exp = {e3, e2, e1, e0}; v.drop = drop;
        return v;
    endfunction

    initial begin
        int ss, t;
        reset = 1'b0; new_nonces = '0; slave_nonces = '0; serial_busy = 1'b0;
        tbl[0] = mk(2'b11, 32'h11111111, 32'h22222222, 2'b11, 32'h11111111, 32'h22222222,
                    2'b00, 0, 0, 40, 4, 32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222, 2'b00);
        tbl[1] = mk(2'b01, 32'h33333333, 0, 2'b10, 0, 32'hAAAA0001, 2'b10, 0, 32'hAAAA0002,
                    3, 2, 32'h33333333, 32'hAAAA0002, 0, 0, 2'b10);
        tbl[2] = mk(2'b01, 32'h00000004, 0, 2'b01, 32'h00000005, 0, 2'b00, 0, 0,
                    1, 2, 32'h00000004, 32'h00000005, 0, 0, 2'b00);
        tbl[3] = mk(2'b10, 0, 32'h000000B1, 2'b00, 0, 0, 2'b01, 32'h000000A0, 0,
                    2, 2, 32'h000000B1, 32'h000000A0, 0, 0, 2'b00);

        // single nonce with a 40-cycle transfer
        do_reset();
        chk("reset pending", 32'(pending), 32'h0);
        tx_len = 40;
        strobe(2'b01, 32'hDEADBEEF, 32'h0);
        step();
        chk("single no early send", 32'(serial_send), 32'h0);
        step();
        chk("single send latency", 32'(serial_send), 32'h1);
        step();
        chk("single pulse width", 32'(serial_send), 32'h0);
        repeat (50) step();
        chk("single golden", golden_nonce, 32'hDEADBEEF);
        chk("single sent", 32'(sent_count), 32'h1);
        chk("single pending", 32'(pending), 32'h0);

        tx_len = 8;
        foreach (tbl[n]) begin
            do_reset();
            for (int e = 0; e < 3; e++) begin
                strobe(tbl[n].s[e], tbl[n].v0[e], tbl[n].v1[e]);
                step();
                repeat (tbl[n].gap - 1) step();
            end
            repeat (120) step();
            chk($sformatf("tbl%0d nsends", n), 32'(dut_sends.size()), 32'(tbl[n].nexp));
            for (int e = 0; e < tbl[n].nexp && e < dut_sends.size(); e++)
                chk($sformatf("tbl%0d send%0d", n, e), dut_sends[e], tbl[n].exp[e]);
            chk($sformatf("tbl%0d dropped", n), 32'(dropped), 32'(tbl[n].drop));
        end

        // transmitter ignores the first send
        do_reset();
        ignore_n = 1;
        strobe(2'b11, 32'h77777777, 32'h88888888);
        step();
        step();
        ss = step_no;
        chk("timeout send", 32'(serial_send), 32'h1);
        t = 0;
        while (!tx_timeout && t < 30) begin step(); t++; end
        chk("timeout latency", 32'(step_no - ss), 32'(TO + 1));
        chk("timeout sent", 32'(sent_count), 32'h0);
        repeat (40) step();
        chk("timeout nsends", 32'(dut_sends.size()), 32'h2);
        if (dut_sends.size() == 2) chk("timeout next", dut_sends[1], 32'h88888888);
        chk("timeout sent after", 32'(sent_count), 32'h1);

        // reset while WAIT_DONE with both slots full
        do_reset();
        tx_len = 40;
        strobe(2'b11, 32'hC0C0C0C0, 32'hD1D1D1D1);
        step();
        repeat (9) step();
        strobe(2'b01, 32'hC1C1C1C1, 32'h0);
        step();
        chk("mid pending", 32'(pending), 32'h3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid rst golden", golden_nonce, 32'h0);
        chk("mid rst pending", 32'(pending), 32'h0);
        chk("mid rst send", 32'(serial_send), 32'h0);
        tx_len = 8;
        strobe(2'b11, 32'hE0E0E0E0, 32'hE1E1E1E1);
        step();
        step();
        chk("post rst priority", golden_nonce, 32'hE0E0E0E0);
        repeat (40) step();

        // sent_count wrap
        do_reset();
        m_sent = 16'hFFFF;
        force dut.sent_q = 16'hFFFF;
        step();
        release dut.sent_q;
        strobe(2'b10, 32'h0, 32'h12345678);
        repeat (30) step();
        chk("wrap sent", 32'(sent_count), 32'h0);

        // randomized traffic with occasional silent transmitter
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0)
                strobe(2'($urandom_range(1, 3)), $urandom, $urandom);
            tx_len = $urandom_range(2, 10);
            if ($urandom_range(0, 63) == 0) ignore_n = 1;
            step();
        end
        repeat (60) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
